// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - shared types, bounds and round-robin search for sr_bank_arbiter
package sr_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int NREQ_MIN  = 2;
  localparam int NREQ_MAX  = 8;
  localparam int NBITS_MIN = 1;
  localparam int NBITS_MAX = 32;

  // First valid index at or after ptr, wrapping modulo nreq; returns ptr if none valid.
  function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                         input logic [NREQ_MAX-1:0] valid,
                                         input int nreq);
    logic [2:0] idx;
    next_rr = ptr;
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = 3'((int'(ptr) + k) % nreq);
        if (valid[idx]) next_rr = idx;
      end
    end
  endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one SR storage cell; holds on S=R=0 and on S=R=1
module sr_cell (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (s && !r) begin
      q <= 1'b1;
    end else if (!s && r) begin
      q <= 1'b0;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin arbiter writing a shared SR bank
// Optional sticky conflict detection: SR_BANK_ARBITER_CONFLICT_EN
module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*NBITS-1:0]      req_set_mask,
  input  logic [NREQ*NBITS-1:0]      req_clr_mask,
  output logic [NREQ-1:0]            req_ack,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy,
  output logic [NBITS-1:0]           q,
  output logic [NBITS-1:0]           qbar,
  output logic                       conflict
);

  localparam int IDW = $clog2(NREQ);

  state_t                state, state_nxt;
  logic [IDW-1:0]        rr_ptr;
  logic [NBITS-1:0]      s_reg, r_reg;
  logic [NBITS-1:0]      s_bus, r_bus;
  logic [NREQ_MAX-1:0]   valid_pad;
  logic [2:0]            winner;

  always_comb begin
    valid_pad = '0;
    valid_pad[NREQ-1:0] = req_valid;
    winner = next_rr(3'(rr_ptr), valid_pad, NREQ);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = APPLY;
      APPLY:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      s_reg    <= '0;
      r_reg    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req_valid) begin
        grant_id <= IDW'(winner);
        s_reg    <= req_set_mask[int'(winner)*NBITS +: NBITS];
        r_reg    <= req_clr_mask[int'(winner)*NBITS +: NBITS];
      end
      if (state == ACK) begin
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  always_comb begin
    req_ack = '0;
    if (state == ACK) req_ack[grant_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Cells see the latched masks only during APPLY, so q holds everywhere else.
  assign s_bus = (state == APPLY) ? s_reg : '0;
  assign r_bus = (state == APPLY) ? r_reg : '0;

  for (genvar b = 0; b < NBITS; b++) begin : g_cell
    sr_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .s     (s_bus[b]),
      .r     (r_bus[b]),
      .q     (q[b]),
      .qbar  (qbar[b])
    );
  end

`ifdef SR_BANK_ARBITER_CONFLICT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict <= 1'b0;
    end else if (state == APPLY && |(s_reg & r_reg)) begin
      conflict <= 1'b1;
    end
  end
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - directed self-checking bench for sr_bank_arbiter
module tb_sr_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_set_mask = '0;
  logic [31:0] req_clr_mask = '0;
  logic [3:0]  req_ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        conflict;

  int checks = 0;
  int errors = 0;

`ifdef SR_BANK_ARBITER_CONFLICT_EN
  localparam logic CONFLICT_EXP = 1'b1;
`else
  localparam logic CONFLICT_EXP = 1'b0;
`endif

  sr_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_set_mask (req_set_mask),
    .req_clr_mask (req_clr_mask),
    .req_ack      (req_ack),
    .grant_id     (grant_id),
    .busy         (busy),
    .q            (q),
    .qbar         (qbar),
    .conflict     (conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request from IDLE: returns grant_id after the grant edge, ack and q after the apply edge.
  task automatic do_req(input int idx, input logic [7:0] set, input logic [7:0] clr,
                        output logic [1:0] gid, output logic [3:0] ack, output logic [7:0] qv);
    req_set_mask[idx*8 +: 8] = set;
    req_clr_mask[idx*8 +: 8] = clr;
    req_valid[idx] = 1'b1;
    tick();
    gid = grant_id;
    tick();
    ack = req_ack;
    qv = q;
    req_valid[idx] = 1'b0;
    req_set_mask[idx*8 +: 8] = '0;
    req_clr_mask[idx*8 +: 8] = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h exp ff", qbar); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp 0", conflict); end
    reset = 1'b0;
  endtask

  task automatic test_set_clear();
    req_set_mask[15:8] = 8'hA5;
    req_valid[1] = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy got %b exp 1", busy); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL set_grant got %0d exp 1", grant_id); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL set_q_early got %h exp 00", q); end
    tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL set_q got %h exp a5", q); end
    checks++; if (qbar !== 8'h5A) begin errors++; $display("FAIL set_qbar got %h exp 5a", qbar); end
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL set_ack got %b exp 0010", req_ack); end
    req_valid[1] = 1'b0;
    req_set_mask[15:8] = 8'h00;
    tick();
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL set_ack_pulse got %b exp 0000", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL set_idle got %b exp 0", busy); end
    req_clr_mask[15:8] = 8'h05;
    req_valid[1] = 1'b1;
    tick();
    tick();
    checks++; if (q !== 8'hA0) begin errors++; $display("FAIL clr_q got %h exp a0", q); end
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL clr_ack got %b exp 0010", req_ack); end
    req_valid[1] = 1'b0;
    req_clr_mask[15:8] = 8'h00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++; if (grant_id !== 2'(g % 4)) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", g, grant_id, g % 4); end
      checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_pre%0d got %b exp 0000", g, req_ack); end
      tick();
      exp_ack = 4'b0001 << (g % 4);
      checks++; if (req_ack !== exp_ack) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", g, req_ack, exp_ack); end
      tick();
      checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_post%0d got %b exp 0000", g, req_ack); end
    end
    req_valid = 4'b0000;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rr_zero_mask_q got %h exp 00", q); end
  endtask

  task automatic test_conflict();
    logic [1:0] gid;
    logic [3:0] ack;
    logic [7:0] qv;
    do_req(3, 8'h0F, 8'h00, gid, ack, qv);
    checks++; if (qv !== 8'h0F) begin errors++; $display("FAIL cf_setup_q got %h exp 0f", qv); end
    do_req(2, 8'h11, 8'h11, gid, ack, qv);
    checks++; if (gid !== 2'd2) begin errors++; $display("FAIL cf_grant got %0d exp 2", gid); end
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL cf_ack got %b exp 0100", ack); end
    checks++; if (qv !== 8'h0F) begin errors++; $display("FAIL cf_q got %h exp 0f", qv); end
    checks++; if (conflict !== CONFLICT_EXP) begin errors++; $display("FAIL cf_flag got %b exp %b", conflict, CONFLICT_EXP); end
    tick();
    tick();
    checks++; if (conflict !== CONFLICT_EXP) begin errors++; $display("FAIL cf_sticky got %b exp %b", conflict, CONFLICT_EXP); end
  endtask

  task automatic test_reset_mid();
    req_set_mask[23:16] = 8'hFF;
    req_valid[2] = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_q got %h exp 00", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_abort got %b exp 0", busy); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL mid_conflict got %b exp 0", conflict); end
    tick();
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL mid_no_ack got %b exp 0000", req_ack); end
    reset = 1'b0;
    req_valid = 4'b1010;
    req_set_mask[23:16] = 8'h00;
    tick();
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL mid_regrant got %0d exp 1", grant_id); end
    tick();
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL mid_reack got %b exp 0010", req_ack); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_ignored_busy();
    req_set_mask[7:0] = 8'h3C;
    req_valid[0] = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL ign_grant got %0d exp 0", grant_id); end
    req_set_mask[7:0] = 8'hFF;
    req_clr_mask[7:0] = 8'hFF;
    tick();
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL ign_q got %h exp 3c", q); end
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL ign_ack got %b exp 0001", req_ack); end
    req_valid = 4'b0000;
    req_set_mask = '0;
    req_clr_mask = '0;
    tick();
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL ign_conflict got %b exp 0", conflict); end
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL ign_hold got %h exp 3c", q); end
  endtask

  initial begin
    tick();
    test_reset();
    test_set_clear();
    test_round_robin();
    test_conflict();
    test_reset_mid();
    test_ignored_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Round-robin arbiter that shares one bank of SR flip-flop cells between several requesters. Each requester presents a set mask and a clear mask. The winner's masks drive the S and R inputs of every cell in the bank for exactly one clock edge, and the winner then receives a one-cycle acknowledge. The block sits between the control agents and the SR storage bank, and it is the only path that writes the bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR cells in the bank (1..32)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_set_mask  in  NREQ*NBITS  requester i's set mask in bits [i*NBITS +: NBITS]
- req_clr_mask  in  NREQ*NBITS  requester i's clear mask, packed the same way
- req_ack  out  NREQ  one-hot, single-cycle acknowledge to the served requester
- grant_id  out  $clog2(NREQ)  index of the current/last granted requester
- busy  out  1  high in states APPLY and ACK
- q  out  NBITS  bank contents
- qbar  out  NBITS  always ~q
- conflict  out  1  sticky conflict flag; tied 0 unless the macro is defined

## Operation
- FSM states: IDLE, APPLY, ACK.
- **IDLE:**
  - If any req_valid is high, select a winner by round-robin.
  - Search starts at index rr_ptr and wraps modulo NREQ.
  - Latch the winner's set and clear masks into s_reg and r_reg, load grant_id, then go to APPLY.
  - If no req_valid is high, stay in IDLE.
- **APPLY:**
  - s_reg and r_reg drive the cell S and R inputs.
  - Each cell updates at the closing edge:
    - S=1, R=0 sets the cell to 1.
    - S=0, R=1 clears the cell to 0.
    - S=0, R=0 holds.
    - S=1, R=1 holds (treated as a conflict).
  - Go to ACK.
- **ACK:**
  - req_ack[grant_id]=1 for this cycle only.
  - rr_ptr becomes (grant_id+1) mod NREQ.
  - Go to IDLE.
- Request inputs are sampled only in IDLE. Changes to req_valid or the masks during APPLY or ACK are ignored.
- A requester must hold its req_valid and masks stable until it sees req_ack. If req_valid is still high in the IDLE cycle after the ack, it counts as a new request.
- Cells are touched only in APPLY. S and R are forced to 0 in all other states, so q holds outside APPLY.
- An all-zero mask pair is a legal request. It still consumes a grant and an ack, and q does not change.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, req_ack=0, busy=0.
  - q=0, qbar=all ones, s_reg=r_reg=0, conflict=0.
- Reset asserted mid-operation aborts the transaction immediately. No ack is issued and the bank is cleared. The aborted requester must re-request.

## Timing
- Request seen at edge N (state IDLE): APPLY during cycle N..N+1.
- q updates at edge N+1.
- req_ack is high during cycle N+1..N+2.
- The block is back in IDLE after edge N+2.
- Latency from request to visible q change: 2 edges. Request to ack: 2 edges.
- Throughput: one command per 3 cycles. Back-to-back requests from different requesters are served at edges N, N+3, N+6, and so on.
- grant_id is valid from edge N and holds until the next grant.
- qbar is combinational from q and never lags it.

## Configuration
- Macro: SR_BANK_ARBITER_CONFLICT_EN.
- **Defined:**
  - In APPLY, if (s_reg & r_reg) != 0, conflict sets at the closing edge.
  - conflict stays set until reset.
  - Conflicting bits still hold.
- **Undefined:**
  - conflict is constant 0 and no detection logic is built.
  - Bank behaviour is identical, including hold on S=R=1.

## Structure
- Package sr_bank_pkg holds:
  - the state enum (IDLE, APPLY, ACK);
  - the NREQ/NBITS bounds;
  - a next_rr(ptr, valid) round-robin function.
- Sub-module sr_cell: one cell per bit.
  - Ports: clk, reset, s, r, q, qbar.
  - Asynchronous active-high reset to q=0.
  - Hold on S=R=0 and on S=R=1.
  - Instantiated NBITS times by a generate loop.

## Test plan
- **Reset behaviour:** assert reset for 2 cycles → q=0x00, qbar=0xFF, req_ack=0, busy=0, grant_id=0.
- **Single set then clear:**
  - Requester 1 sends set_mask=0xA5, clr=0x00 → q=0xA5 after 2 edges, and req_ack=0b0010 for exactly 1 cycle.
  - It then sends clr_mask=0x05 → q=0xA0.
- **Round-robin fairness:** all 4 requesters valid continuously → grants in order 0,1,2,3,0, one every 3 cycles, each ack a single pulse.
- **Conflict:**
  - q=0x0F, requester 2 sends set=0x11, clr=0x11 → bit0 holds 1, bit4 holds 0, q=0x0F.
  - With SR_BANK_ARBITER_CONFLICT_EN defined, conflict rises and stays 1.
  - With the macro undefined, conflict stays 0.
- **Reset mid-operation:** assert reset during APPLY with set=0xFF → q=0x00, no req_ack pulse, rr_ptr=0, and the next grant goes to the lowest valid index.
- **Ignored inputs while busy:** change requester 0's masks during APPLY → the applied value is the one latched in IDLE.
